rf_port_arbiter: RTL and testbench

Shares the register file's single write port and its second read port between the CPU datapath and a UART debug requester (register peek/poke). The CPU has priority. Debug writes complete opportunistically in cycles where the CPU does not write. Debug reads, and debug writes starved for MAX_WAIT cycles, freeze the CPU for exactly one cycle via cpu_stall. The block sits between the CPU writeback/decode stage, the UART debug engine and the register file.

---
 rtl/rf_port_arbiter_pkg.sv | 20 ++
 rtl/rf_port_mux.sv | 43 ++++
 rtl/rf_port_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_port_arbiter_pkg.sv
// rf_port_arbiter_pkg: shared arbiter state encodings, register indices and helpers.
// Revision 1.0
`default_nettype none

package rf_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_WAIT  = 2'd1;
  localparam logic [1:0] ARB_STALL = 2'd2;

  localparam logic [4:0] RF_ZERO_REG = 5'd0;

  // Counter must hold values 0..max_wait; keep at least one bit when max_wait is 0
  function automatic int cnt_width(input int max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_port_mux.sv
// rf_port_mux: selects the write port and read port 2 between CPU and debug, with r0 suppression.
// Revision 1.0
`default_nettype none

module rf_port_mux
  import rf_port_arbiter_pkg::*;
#(
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic        cpu_we,
  input  logic [4:0]  cpu_wa,
  input  logic [31:0] cpu_wd,
  input  logic [4:0]  cpu_ra2,
  input  logic        cpu_mask,
  input  logic        dbg_wr_sel,
  input  logic        dbg_rd_sel,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [4:0]  rf_ra2
);

  logic we_raw;

  always_comb begin
    we_raw = cpu_we & ~cpu_mask;
    rf_wa  = cpu_wa;
    rf_wd  = cpu_wd;
    if (dbg_wr_sel) begin
      we_raw = 1'b1;
      rf_wa  = dbg_addr;
      rf_wd  = dbg_wdata;
    end
    rf_ra2 = dbg_rd_sel ? dbg_addr : cpu_ra2;
    // Writes to r0 are still routed but never reach the array
    rf_we  = we_raw & ~(PROTECT_R0 && (rf_wa == RF_ZERO_REG));
  end

endmodule

`default_nettype wire

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares the RF write port and read port 2 between the CPU and a debug requester.
// Revision 1.0
`default_nettype none

module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT   = 8,
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_wa,
  input  logic [31:0] cpu_wd,
  input  logic [4:0]  cpu_ra2,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_wr,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd2
);

  localparam int            CW       = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt, cnt_nxt;
  logic          wr_sel, rd_sel, cpu_mask, rd_fire;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    dbg_gnt   = 1'b0;
    wr_sel    = 1'b0;
    rd_sel    = 1'b0;
    cpu_mask  = 1'b0;
    rd_fire   = 1'b0;
    case (state)
      ARB_IDLE, ARB_WAIT: begin
        if (!dbg_req) begin
          state_nxt = ARB_IDLE;
          cnt_nxt   = '0;
        end else if (!dbg_wr) begin
          state_nxt = ARB_STALL;
          cnt_nxt   = '0;
        end else if (!cpu_we) begin
          wr_sel    = 1'b1;
          dbg_gnt   = 1'b1;
          state_nxt = ARB_IDLE;
          cnt_nxt   = '0;
        end else if (state == ARB_IDLE) begin
          state_nxt = (MAX_WAIT == 0) ? ARB_STALL : ARB_WAIT;
          cnt_nxt   = '0;
        end else begin
          // Starved: count CPU-occupied cycles, force a stall on the last one
          if (wait_cnt != CNT_SAT) cnt_nxt = wait_cnt + 1'b1;
          if (wait_cnt >= CNT_LAST) state_nxt = ARB_STALL;
        end
      end
      ARB_STALL: begin
        cpu_mask  = 1'b1;
        state_nxt = ARB_IDLE;
        cnt_nxt   = '0;
        if (dbg_req) begin
          dbg_gnt = 1'b1;
          if (dbg_wr) begin
            wr_sel = 1'b1;
          end else begin
            rd_sel  = 1'b1;
            rd_fire = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      wait_cnt   <= '0;
      cpu_stall  <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= cnt_nxt;
      cpu_stall  <= (state_nxt == ARB_STALL);
      dbg_rvalid <= rd_fire;
      if (rd_fire) dbg_rdata <= rf_rd2;
    end
  end

  rf_port_mux #(
    .PROTECT_R0 (PROTECT_R0)
  ) u_mux (
    .cpu_we     (cpu_we),
    .cpu_wa     (cpu_wa),
    .cpu_wd     (cpu_wd),
    .cpu_ra2    (cpu_ra2),
    .cpu_mask   (cpu_mask),
    .dbg_wr_sel (wr_sel),
    .dbg_rd_sel (rd_sel),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .rf_ra2     (rf_ra2)
  );

endmodule

`default_nettype wire

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed self-checking bench for rf_port_arbiter with a behavioural register file.
// Revision 1.0
`default_nettype none

module tb_rf_port_arbiter;
  import rf_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_we;
  logic [4:0]  cpu_wa;
  logic [31:0] cpu_wd;
  logic [4:0]  cpu_ra2;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_wr;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  rf_ra2;
  logic [31:0] rf_rd2;

  logic [31:0] regs [32];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_port_arbiter #(.MAX_WAIT(8), .PROTECT_R0(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_we     (cpu_we),
    .cpu_wa     (cpu_wa),
    .cpu_wd     (cpu_wd),
    .cpu_ra2    (cpu_ra2),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_wr     (dbg_wr),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .rf_ra2     (rf_ra2),
    .rf_rd2     (rf_rd2)
  );

  // Behavioural register file
  always @(posedge clk) if (rf_we) regs[rf_wa] <= rf_wd;
  assign rf_rd2 = regs[rf_ra2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  int stall_cnt;
  int gnt_cyc;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rst_n = 1'b0; cpu_we = 1'b0; cpu_wa = '0; cpu_wd = '0; cpu_ra2 = '0;
    dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset state
    #2;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rvalid", dbg_rvalid, 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_gnt", dbg_gnt, 0);
    next_cyc(); next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // Opportunistic debug write r5
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("opp_we", rf_we, 1);
    chk("opp_wa", rf_wa, 5);
    chk("opp_wd", rf_wd, 32'hDEADBEEF);
    chk("opp_gnt", dbg_gnt, 1);
    chk("opp_stall", cpu_stall, 0);
    next_cyc();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("opp_stall_after", cpu_stall, 0);
    chk("opp_rf5", regs[5], 32'hDEADBEEF);

    // CPU pre-writes r3 through default routing
    next_cyc();
    cpu_we = 1'b1; cpu_wa = 5'd3; cpu_wd = 32'h000000AB;
    @(negedge clk);
    chk("cpu_we", rf_we, 1);
    chk("cpu_wa", rf_wa, 3);
    next_cyc();

    // Starved debug write r7 while CPU writes every cycle
    cpu_we = 1'b1; cpu_wa = 5'd10;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h12345678;
    stall_cnt = 0; gnt_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      cpu_wd = 32'h11110000 + c;
      @(negedge clk);
      if (cpu_stall) stall_cnt++;
      if (dbg_gnt) begin
        gnt_cyc = c;
        chk("starve_wa", rf_wa, 7);
        chk("starve_wd", rf_wd, 32'h12345678);
        chk("starve_we", rf_we, 1);
        chk("starve_stall", cpu_stall, 1);
      end else begin
        chk("starve_cpu_wa", rf_wa, 10);
        chk("starve_cpu_we", rf_we, 1);
      end
      next_cyc();
      if (gnt_cyc >= 0) dbg_req = 1'b0;
    end
    chk("starve_gnt_cycle", gnt_cyc, 9);
    chk("starve_stall_count", stall_cnt, 1);
    chk("starve_rf7", regs[7], 32'h12345678);

    // Debug read r3 while CPU streams
    cpu_ra2 = 5'd9; dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd3;
    @(negedge clk);
    chk("rd_c0_stall", cpu_stall, 0);
    chk("rd_c0_gnt", dbg_gnt, 0);
    chk("rd_c0_ra2", rf_ra2, 9);
    next_cyc();
    @(negedge clk);
    chk("rd_c1_stall", cpu_stall, 1);
    chk("rd_c1_gnt", dbg_gnt, 1);
    chk("rd_c1_ra2", rf_ra2, 3);
    chk("rd_c1_cpu_masked", rf_we, 0);
    next_cyc();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("rd_c2_rvalid", dbg_rvalid, 1);
    chk("rd_c2_rdata", dbg_rdata, 32'h000000AB);
    chk("rd_c2_stall", cpu_stall, 0);
    chk("rd_c2_cpu_we", rf_we, 1);
    next_cyc();
    @(negedge clk);
    chk("rd_c3_rvalid", dbg_rvalid, 0);
    chk("rd_c3_rdata_held", dbg_rdata, 32'h000000AB);
    next_cyc();

    // Debug write to r0 is granted but suppressed, then read back r0
    cpu_we = 1'b0;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("r0_gnt", dbg_gnt, 1);
    chk("r0_we", rf_we, 0);
    next_cyc();
    dbg_wr = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("r0rd_gnt", dbg_gnt, 1);
    next_cyc();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("r0rd_rvalid", dbg_rvalid, 1);
    chk("r0rd_rdata", dbg_rdata, 0);
    next_cyc();

    // Reset pulsed while in WAIT
    cpu_we = 1'b1; cpu_wa = 5'd11;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hCAFEF00D;
    next_cyc(); next_cyc();
    @(negedge clk);
    chk("rstw_in_wait", dut.state, ARB_WAIT);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_state", dut.state, ARB_IDLE);
    chk("rstw_stall", cpu_stall, 0);
    chk("rstw_gnt", dbg_gnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; dbg_req = 1'b0;
    @(negedge clk);
    chk("rstw_after_stall", cpu_stall, 0);
    next_cyc();

    // Complete read of r3, then reset while the next read is in STALL
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd3;
    next_cyc(); next_cyc();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("rsts_pre_rdata", dbg_rdata, 32'h000000AB);
    next_cyc();
    dbg_req = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("rsts_in_stall", cpu_stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rsts_stall", cpu_stall, 0);
    chk("rsts_gnt", dbg_gnt, 0);
    chk("rsts_rdata", dbg_rdata, 0);
    chk("rsts_rvalid", dbg_rvalid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; dbg_req = 1'b0;
    @(negedge clk);
    chk("rsts_after_rvalid", dbg_rvalid, 0);
    chk("rsts_after_stall", cpu_stall, 0);
    next_cyc();

    // Abort a starved write after 3 cycles
    cpu_we = 1'b1;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd8; dbg_wdata = 32'h0BADC0DE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_gnt", dbg_gnt, 0);
      chk("abort_stall", cpu_stall, 0);
      next_cyc();
    end
    dbg_req = 1'b0;
    @(negedge clk);
    chk("abort_drop_gnt", dbg_gnt, 0);
    next_cyc();
    @(negedge clk);
    chk("abort_state", dut.state, ARB_IDLE);
    chk("abort_cnt", 32'(dut.wait_cnt), 0);
    chk("abort_stall_end", cpu_stall, 0);
    chk("abort_rf8", regs[8], 0);
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
